// File: rtl/mux_result_checker_if.sv
// Producer-side bus of the dice/traffic-light mux: mode select, button and 3-bit result.
// The producer drives it (master); monitors only observe it (slave).
interface mux_result_checker_if;
  logic       sel;
  logic       button;
  logic [2:0] result;

  modport master (output sel, output button, output result);
  modport slave  (input  sel, input  button, input  result);
endinterface

// File: rtl/mux_result_checker.sv
// Receive-side monitor for the mux result bus: checks every result transition against the
// active mode's legal sequence, records the first violation, reports dice rolls and traffic cycles.
module mux_result_checker #(
  parameter int ERR_W = 8,
  parameter int CYC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_result_checker_if.slave  bus,
  output logic                 err,
  output logic [ERR_W-1:0]     err_count,
  output logic [2:0]           bad_prev,
  output logic [2:0]           bad_now,
  output logic                 roll_valid,
  output logic [2:0]           roll_value,
  output logic [CYC_W-1:0]     cycle_count
);

  typedef enum logic {SYNC, TRACK} state_t;

  state_t           state_q, state_d;
  logic [2:0]       p_res_q, p_res_d;
  logic             p_btn_q, p_btn_d;
  logic             p_sel_q, p_sel_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [2:0]       bad_prev_q, bad_prev_d;
  logic [2:0]       bad_now_q, bad_now_d;
  logic             roll_valid_q, roll_valid_d;
  logic [2:0]       roll_value_q, roll_value_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;

  logic check;
  logic legal;

  // Legality of the current result given the registered history, for the current mode.
  always_comb begin
    legal = 1'b0;
    if (!bus.sel) begin
      if (p_res_q == 3'd0 || p_res_q == 3'd7)
        legal = (bus.result == 3'd1);
      else if (p_btn_q)
        legal = (p_res_q == 3'd6) ? (bus.result == 3'd1) : (bus.result == p_res_q + 3'd1);
      else
        legal = (bus.result == p_res_q);
    end else begin
      unique case (p_res_q)
        3'b100:  legal = (bus.result == 3'b110);
        3'b110:  legal = (bus.result == 3'b001);
        3'b001:  legal = (bus.result == 3'b010);
        3'b010:  legal = (bus.result == 3'b100);
        default: legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    p_res_d       = bus.result;
    p_btn_d       = bus.button;
    p_sel_d       = bus.sel;
    err_d         = err_q;
    err_count_d   = err_count_q;
    bad_prev_d    = bad_prev_q;
    bad_now_d     = bad_now_q;
    roll_valid_d  = 1'b0;
    roll_value_d  = roll_value_q;
    cycle_count_d = cycle_count_q;
    check         = 1'b0;

    unique case (state_q)
      SYNC:  state_d = TRACK;
      TRACK: begin
        // A mode switch makes the history meaningless, so skip this edge and resync.
        if (bus.sel != p_sel_q) state_d = SYNC;
        else                    check   = 1'b1;
      end
      default: state_d = SYNC;
    endcase

    if (check && !legal) begin
      err_d = 1'b1;
      if (!(&err_count_q)) err_count_d = err_count_q + 1'b1;
      if (!err_q) begin
        bad_prev_d = p_res_q;
        bad_now_d  = bus.result;
      end
    end

    if (check && !bus.sel && p_btn_q && !bus.button &&
        bus.result >= 3'd1 && bus.result <= 3'd6) begin
      roll_valid_d = 1'b1;
      roll_value_d = bus.result;
    end

    if (check && bus.sel && p_res_q == 3'b010 && bus.result == 3'b100)
      cycle_count_d = cycle_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q       <= SYNC;
      p_res_q       <= '0;
      p_btn_q       <= 1'b0;
      p_sel_q       <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      bad_prev_q    <= '0;
      bad_now_q     <= '0;
      roll_valid_q  <= 1'b0;
      roll_value_q  <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      p_res_q       <= p_res_d;
      p_btn_q       <= p_btn_d;
      p_sel_q       <= p_sel_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      bad_prev_q    <= bad_prev_d;
      bad_now_q     <= bad_now_d;
      roll_valid_q  <= roll_valid_d;
      roll_value_q  <= roll_value_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign err         = err_q;
  assign err_count   = err_count_q;
  assign bad_prev    = bad_prev_q;
  assign bad_now     = bad_now_q;
  assign roll_valid  = roll_valid_q;
  assign roll_value  = roll_value_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mux_result_checker.sv
// Self-checking bench for mux_result_checker: a per-edge reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mux_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       err;
  logic [7:0] err_count;
  logic [2:0] bad_prev;
  logic [2:0] bad_now;
  logic       roll_valid;
  logic [2:0] roll_value;
  logic [7:0] cycle_count;

  int total = 0;
  int bad   = 0;

  mux_result_checker_if bus ();

  mux_result_checker #(.ERR_W(8), .CYC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err         (err),
    .err_count   (err_count),
    .bad_prev    (bad_prev),
    .bad_now     (bad_now),
    .roll_valid  (roll_valid),
    .roll_value  (roll_value),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: legality expressed as "what must come next" in each mode.
  function automatic bit model_legal(bit s, bit pb, logic [2:0] pr, logic [2:0] r);
    logic [2:0] seq [4];
    int face;
    seq = '{3'b100, 3'b110, 3'b001, 3'b010};
    if (!s) begin
      if (pr == 3'd0 || pr == 3'd7) return r == 3'd1;
      face = pb ? (int'(pr) % 6) + 1 : int'(pr);
      return int'(r) == face;
    end
    for (int i = 0; i < 4; i++)
      if (seq[i] == pr) return r == seq[(i + 1) % 4];
    return 1'b0;
  endfunction

  bit         model_ready = 1'b0;
  bit         resync_pending;   // next edge only records history
  bit         h_sel, h_btn;
  logic [2:0] h_res;
  bit         m_err;
  int         m_cnt, m_cyc;
  logic [2:0] m_bprev, m_bnow, m_rval;
  bit         m_rvalid;

  always @(posedge clk) begin
    if (!rst) begin
      model_ready    = 1'b1;
      resync_pending = 1'b1;
      h_sel = 0; h_btn = 0; h_res = 0;
      m_err = 0; m_cnt = 0; m_cyc = 0;
      m_bprev = 0; m_bnow = 0; m_rval = 0; m_rvalid = 0;
    end else begin
      m_rvalid = 1'b0;
      if (resync_pending) begin
        resync_pending = 1'b0;
      end else if (bus.sel != h_sel) begin
        resync_pending = 1'b1;
      end else begin
        if (!model_legal(bus.sel, h_btn, h_res, bus.result)) begin
          if (!m_err) begin
            m_bprev = h_res;
            m_bnow  = bus.result;
          end
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else if (bus.sel && h_res == 3'b010) begin
          m_cyc = (m_cyc + 1) % 256;
        end
        if (!bus.sel && h_btn && !bus.button && bus.result >= 3'd1 && bus.result <= 3'd6) begin
          m_rvalid = 1'b1;
          m_rval   = bus.result;
        end
      end
      h_sel = bus.sel;
      h_btn = bus.button;
      h_res = bus.result;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("err",         32'(err),         32'(m_err));
      check("err_count",   32'(err_count),   32'(m_cnt));
      check("bad_prev",    32'(bad_prev),    32'(m_bprev));
      check("bad_now",     32'(bad_now),     32'(m_bnow));
      check("roll_valid",  32'(roll_valid),  32'(m_rvalid));
      check("roll_value",  32'(roll_value),  32'(m_rval));
      check("cycle_count", 32'(cycle_count), 32'(m_cyc));
    end
  end

  // One clock edge with the given inputs; returns just after the edge.
  task automatic step(input bit r, input bit s, input bit b, input logic [2:0] res);
    @(negedge clk);
    rst        = r;
    bus.sel    = s;
    bus.button = b;
    bus.result = res;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] faces [7];
    logic [2:0] lights [4];
    faces  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    lights = '{3'b100, 3'b110, 3'b001, 3'b010};
    bus.sel = 0; bus.button = 0; bus.result = 0;

    // 1. reset, then dice recovery 0 -> 1 and hold
    step(0, 0, 0, 3'd0);
    step(0, 0, 0, 3'd0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", 32'(err_count), 0);
    step(1, 0, 0, 3'd0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 3'd1);
    check("t1_err", 32'(err), 0);
    check("t1_cnt", 32'(err_count), 0);

    // 2. dice counting with wrap 6 -> 1, then a roll landing on 4
    foreach (faces[i]) step(1, 0, 1, faces[i]);
    check("t2_err", 32'(err), 0);
    step(1, 0, 1, 3'd2);
    step(1, 0, 1, 3'd3);
    step(1, 0, 0, 3'd4);
    check("t2_roll_valid", 32'(roll_valid), 1);
    check("t2_roll_value", 32'(roll_value), 4);
    step(1, 0, 0, 3'd4);
    check("t2_roll_clear", 32'(roll_valid), 0);
    check("t2_roll_hold",  32'(roll_value), 4);

    // 3. traffic: three full cycles
    for (int k = 0; k < 3; k++)
      foreach (lights[i]) step(1, 1, 0, lights[i]);
    step(1, 1, 0, 3'b100);
    check("t3_err", 32'(err), 0);
    check("t3_cycles", 32'(cycle_count), 3);

    // 4. traffic violation 110 -> 010, then legal steps
    step(1, 1, 0, 3'b110);
    step(1, 1, 0, 3'b010);
    check("t4_err", 32'(err), 1);
    check("t4_cnt", 32'(err_count), 1);
    check("t4_bad_prev", 32'(bad_prev), 32'(3'b110));
    check("t4_bad_now",  32'(bad_now),  32'(3'b010));
    step(1, 1, 0, 3'b100);
    step(1, 1, 0, 3'b110);
    check("t4_cnt_hold", 32'(err_count), 1);
    check("t4_cycles", 32'(cycle_count), 4);

    // 5. toggling mode every edge never checks
    step(0, 1, 0, 3'd0);
    for (int i = 0; i < 12; i++) step(1, i[0], ~i[0], 3'((i * 5 + 3) % 8));
    check("t5_err", 32'(err), 0);
    check("t5_cnt", 32'(err_count), 0);

    // 6. saturate the error counter, then reset
    for (int i = 0; i < 3; i++) step(1, 0, 0, 3'd1);
    for (int i = 0; i < 300; i++) step(1, 0, 0, i[0] ? 3'd1 : 3'd3);
    check("t6_err", 32'(err), 1);
    check("t6_sat", 32'(err_count), 255);
    check("t6_bad_prev", 32'(bad_prev), 1);
    check("t6_bad_now",  32'(bad_now),  3);
    step(0, 0, 0, 3'd3);
    check("t6_rst_err",  32'(err), 0);
    check("t6_rst_cnt",  32'(err_count), 0);
    check("t6_rst_bad",  32'({bad_prev, bad_now}), 0);
    check("t6_rst_roll", 32'({roll_valid, roll_value}), 0);
    check("t6_rst_cyc",  32'(cycle_count), 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
